// File: rtl/unified_mem_pkg.sv
// Shared types and defaults for the unified memory controller: access opcodes,
// controller states and the default memory geometry.
package unified_mem_pkg;

    localparam int MEM_SIZE_DEF = 512;
    localparam int NUM_REGS_DEF = 32;
    localparam int AW_DEF       = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_ST   = 2'b01,
        MEM_LD   = 2'b10,
        MEM_BAD  = 2'b11
    } mem_op_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic logic word_aligned(input logic [1:0] byte_lsb);
        return byte_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with NRD registered read ports (read-first) and NWR write
// ports, where a lower-numbered write port wins when two target the same word.
module mem_word_array
    import unified_mem_pkg::*;
#(
    parameter int DEPTH = MEM_SIZE_DEF / 4,
    parameter int NRD   = 4,
    parameter int NWR   = 3,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [IW-1:0] rd_addr_i [NRD],
    output logic [31:0]   rd_data_o [NRD],
    input  logic          we_i      [NWR],
    input  logic [IW-1:0] waddr_i   [NWR],
    input  logic [31:0]   wdata_i   [NWR]
);

    logic [31:0] mem_q [DEPTH];

    // Highest port index is applied first so port 0's assignment is the last one standing.
    always_ff @(posedge clk) begin
        for (int w = NWR - 1; w >= 0; w--) begin
            if (we_i[w]) begin
                mem_q[waddr_i[w]] <= wdata_i[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NRD; r++) begin
            rd_data_o[r] <= mem_q[rd_addr_i[r]];
        end
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/register/data memory: register file in the bottom words,
// post-reset clear of that region, range/alignment checking and a sticky error flag.
module unified_mem_ctrl
    import unified_mem_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ins_addr,
    output logic [31:0]   ins_data,
    input  logic [AW-1:0] load_pc_reg_addr1,
    input  logic [AW-1:0] load_pc_reg_addr2,
    output logic [31:0]   load_pc_reg_value1,
    output logic [31:0]   load_pc_reg_value2,
    input  logic          op_write_top,
    input  logic [AW-1:0] write_pc_reg_addr,
    input  logic [31:0]   write_pc_reg_value,
    input  logic [1:0]    mem_ctrl_input,
    input  logic [AW-1:0] address,
    input  logic [31:0]   w_data,
    output logic [31:0]   read_data,
    output logic          mem_valid,
    output logic          busy,
    output logic          mem_err,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [31:0]   init_data
);

    localparam int DEPTH = MEM_SIZE / 4;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);
    localparam logic [AW-1:0] REG_LIMIT = AW'(NUM_REGS);
    localparam logic [IW-1:0] CLR_LAST  = IW'(NUM_REGS - 1);

    state_e        state_q;
    logic [IW-1:0] clr_idx_q;
    logic          busy_q;
    logic          mem_err_q;
    logic          fetch_ok_q;
    logic [1:0]    reg_ok_q;
    logic [1:0]    reg_byp_q;
    logic [31:0]   byp_data_q;
    logic          ld_ok_q;
    logic          ld_zero_q;
    logic [31:0]   read_hold_q;

    logic          run;
    mem_op_e       op;
    logic          data_oor;
    logic          data_aligned;
    logic          fetch_oor;
    logic          wb_oor;
    logic          wb_en;
    logic          st_en;
    logic          ld_en;
    logic          ld_zero;
    logic          init_en;
    logic          err_d;

    logic [AW-1:0] reg_addr  [2];
    logic [1:0]    reg_oor;
    logic [1:0]    reg_byp;
    logic [1:0]    reg_rd_ok;
    logic [31:0]   reg_val   [2];

    logic [IW-1:0] rd_addr   [4];
    logic [31:0]   rd_data   [4];
    logic          we        [3];
    logic [IW-1:0] waddr     [3];
    logic [31:0]   wdata     [3];

    assign run          = (state_q == ST_RUN);
    assign op           = mem_op_e'(mem_ctrl_input);
    assign data_oor     = (address >= MEM_LIMIT);
    assign data_aligned = word_aligned(address[1:0]);
    assign fetch_oor    = (ins_addr >= MEM_LIMIT);
    assign wb_oor       = (write_pc_reg_addr >= REG_LIMIT);

    assign wb_en   = run && op_write_top && !wb_oor && (write_pc_reg_addr != '0);
    assign st_en   = run && (op == MEM_ST) && data_aligned && !data_oor;
    assign ld_en   = run && (op == MEM_LD) && data_aligned && !data_oor;
    assign ld_zero = run && (op == MEM_LD) && data_oor;
    assign init_en = run && init_we && (init_addr < MEM_LIMIT);

    assign reg_addr[0] = load_pc_reg_addr1;
    assign reg_addr[1] = load_pc_reg_addr2;

    // A same-edge writeback to a read index forwards the new value (write-first).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reg_port
            assign reg_oor[gi]   = (reg_addr[gi] >= REG_LIMIT);
            assign reg_byp[gi]   = run && op_write_top && !reg_oor[gi]
                                   && (reg_addr[gi] != '0)
                                   && (write_pc_reg_addr == reg_addr[gi]);
            assign reg_rd_ok[gi] = run && !reg_oor[gi] && (reg_addr[gi] != '0) && !reg_byp[gi];
            assign reg_val[gi]   = reg_byp_q[gi] ? byp_data_q :
                                   reg_ok_q[gi]  ? rd_data[1 + gi] : 32'h0;
            assign rd_addr[1 + gi] = reg_addr[gi][IW-1:0];
        end
    endgenerate

    assign rd_addr[0] = ins_addr[IW+1:2];
    assign rd_addr[3] = address[IW+1:2];

    // Port 0 is shared by the clear sequence and preload; they never overlap in time.
    assign we[0]    = run ? init_en : 1'b1;
    assign waddr[0] = run ? init_addr[IW+1:2] : clr_idx_q;
    assign wdata[0] = run ? init_data : 32'h0;
    assign we[1]    = st_en;
    assign waddr[1] = address[IW+1:2];
    assign wdata[1] = w_data;
    assign we[2]    = wb_en;
    assign waddr[2] = write_pc_reg_addr[IW-1:0];
    assign wdata[2] = write_pc_reg_value;

    mem_word_array #(
        .DEPTH (DEPTH),
        .NRD   (4),
        .NWR   (3)
    ) u_array (
        .clk       (clk),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata)
    );

    assign err_d = fetch_oor
                 || (reg_oor != 2'b00)
                 || (op_write_top && wb_oor)
                 || (op == MEM_BAD)
                 || (((op == MEM_LD) || (op == MEM_ST)) && (!data_aligned || data_oor));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            busy_q      <= 1'b1;
            mem_err_q   <= 1'b0;
            fetch_ok_q  <= 1'b0;
            reg_ok_q    <= 2'b00;
            reg_byp_q   <= 2'b00;
            byp_data_q  <= 32'h0;
            ld_ok_q     <= 1'b0;
            ld_zero_q   <= 1'b0;
            read_hold_q <= 32'h0;
        end else begin
            read_hold_q <= read_data;
            case (state_q)
                ST_CLEAR: begin
                    fetch_ok_q <= 1'b0;
                    reg_ok_q   <= 2'b00;
                    reg_byp_q  <= 2'b00;
                    ld_ok_q    <= 1'b0;
                    ld_zero_q  <= 1'b0;
                    clr_idx_q  <= clr_idx_q + IW'(1);
                    if (clr_idx_q == CLR_LAST) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    fetch_ok_q <= !fetch_oor;
                    reg_ok_q   <= reg_rd_ok;
                    reg_byp_q  <= reg_byp;
                    byp_data_q <= write_pc_reg_value;
                    ld_ok_q    <= ld_en;
                    ld_zero_q  <= ld_zero;
                    if (err_d) begin
                        mem_err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ins_data           = fetch_ok_q ? rd_data[0] : 32'h0;
    assign load_pc_reg_value1 = reg_val[0];
    assign load_pc_reg_value2 = reg_val[1];
    assign read_data          = ld_ok_q ? rd_data[3] : (ld_zero_q ? 32'h0 : read_hold_q);
    assign mem_valid          = ld_ok_q;
    assign busy               = busy_q;
    assign mem_err            = mem_err_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: clear sequence, register bypass,
// load/store byte order, fetch, write collisions and error handling.
module tb_unified_mem_ctrl;
    import unified_mem_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ins_addr;
    logic [31:0]   ins_data;
    logic [AW-1:0] load_pc_reg_addr1;
    logic [AW-1:0] load_pc_reg_addr2;
    logic [31:0]   load_pc_reg_value1;
    logic [31:0]   load_pc_reg_value2;
    logic          op_write_top;
    logic [AW-1:0] write_pc_reg_addr;
    logic [31:0]   write_pc_reg_value;
    logic [1:0]    mem_ctrl_input;
    logic [AW-1:0] address;
    logic [31:0]   w_data;
    logic [31:0]   read_data;
    logic          mem_valid;
    logic          busy;
    logic          mem_err;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [31:0]   init_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt;

    always #5 clk = ~clk;

    unified_mem_ctrl #(
        .MEM_SIZE (512),
        .NUM_REGS (32),
        .AW       (AW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ins_addr           (ins_addr),
        .ins_data           (ins_data),
        .load_pc_reg_addr1  (load_pc_reg_addr1),
        .load_pc_reg_addr2  (load_pc_reg_addr2),
        .load_pc_reg_value1 (load_pc_reg_value1),
        .load_pc_reg_value2 (load_pc_reg_value2),
        .op_write_top       (op_write_top),
        .write_pc_reg_addr  (write_pc_reg_addr),
        .write_pc_reg_value (write_pc_reg_value),
        .mem_ctrl_input     (mem_ctrl_input),
        .address            (address),
        .w_data             (w_data),
        .read_data          (read_data),
        .mem_valid          (mem_valid),
        .busy               (busy),
        .mem_err            (mem_err),
        .init_we            (init_we),
        .init_addr          (init_addr),
        .init_data          (init_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got %h", tag, got);
        end else begin
            $display("FAIL %-14s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        ins_addr           = '0;
        load_pc_reg_addr1  = '0;
        load_pc_reg_addr2  = '0;
        op_write_top       = 1'b0;
        write_pc_reg_addr  = '0;
        write_pc_reg_value = '0;
        mem_ctrl_input     = MEM_IDLE;
        address            = '0;
        w_data             = '0;
        init_we            = 1'b0;
        init_addr          = '0;
        init_data          = '0;
    endtask

    // Counts sampled cycles with busy high; the first n_bad of them drive an illegal op.
    task automatic count_busy(input int n_bad, output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n < n_bad) mem_ctrl_input = MEM_BAD;
            else           mem_ctrl_input = MEM_IDLE;
            n++;
            step();
        end
        mem_ctrl_input = MEM_IDLE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a);
        mem_ctrl_input = MEM_LD;
        address        = a;
        step();
        mem_ctrl_input = MEM_IDLE;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
        mem_ctrl_input = MEM_ST;
        address        = a;
        w_data         = d;
        step();
        mem_ctrl_input = MEM_IDLE;
    endtask

    initial begin
        go_idle();
        reset = 1'b1;
        step();
        step();
        check_eq("rst_ins", ins_data, 32'h0);
        check_eq("rst_v1", load_pc_reg_value1, 32'h0);
        check_eq("rst_v2", load_pc_reg_value2, 32'h0);
        check_eq("rst_rdata", read_data, 32'h0);
        check_eq("rst_valid", {31'h0, mem_valid}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h1);
        check_eq("rst_err", {31'h0, mem_err}, 32'h0);

        reset = 1'b0;
        count_busy(5, cnt);
        check_eq("clear_len", cnt, 32);
        check_eq("clear_err", {31'h0, mem_err}, 32'h0);

        load_pc_reg_addr1 = 1;
        load_pc_reg_addr2 = 31;
        step();
        check_eq("reg1_zero", load_pc_reg_value1, 32'h0);
        check_eq("reg31_zero", load_pc_reg_value2, 32'h0);

        op_write_top       = 1'b1;
        write_pc_reg_addr  = 5;
        write_pc_reg_value = 32'hDEADBEEF;
        load_pc_reg_addr1  = 5;
        step();
        check_eq("bypass_r5", load_pc_reg_value1, 32'hDEADBEEF);
        op_write_top = 1'b0;
        load_pc_reg_addr2 = 5;
        step();
        check_eq("stored_r5", load_pc_reg_value2, 32'hDEADBEEF);

        op_write_top       = 1'b1;
        write_pc_reg_addr  = 0;
        write_pc_reg_value = 32'h00001234;
        load_pc_reg_addr1  = 0;
        step();
        check_eq("r0_bypass", load_pc_reg_value1, 32'h0);
        op_write_top = 1'b0;
        step();
        check_eq("r0_after", load_pc_reg_value1, 32'h0);

        store(32'h100, 32'h11223344);
        check_eq("st_novalid", {31'h0, mem_valid}, 32'h0);
        load(32'h100);
        check_eq("ld_word", read_data, 32'h11223344);
        check_eq("ld_byte0", {24'h0, read_data[7:0]}, 32'h44);
        check_eq("ld_byte3", {24'h0, read_data[31:24]}, 32'h11);
        check_eq("ld_valid", {31'h0, mem_valid}, 32'h1);
        step();
        check_eq("valid_pulse", {31'h0, mem_valid}, 32'h0);
        check_eq("rdata_hold", read_data, 32'h11223344);

        init_we   = 1'b1;
        init_addr = 32'h80;
        init_data = 32'h00500093;
        step();
        init_we  = 1'b0;
        ins_addr = 32'h80;
        step();
        check_eq("fetch_80", ins_data, 32'h00500093);
        store(32'h80, 32'hAAAA5555);
        check_eq("fetch_rdfirst", ins_data, 32'h00500093);
        step();
        check_eq("fetch_new", ins_data, 32'hAAAA5555);
        ins_addr = 0;

        op_write_top       = 1'b1;
        write_pc_reg_addr  = 5;
        write_pc_reg_value = 32'h55555555;
        load_pc_reg_addr1  = 0;
        load_pc_reg_addr2  = 0;
        store(32'h14, 32'hCAFEF00D);
        op_write_top      = 1'b0;
        load_pc_reg_addr1 = 5;
        step();
        check_eq("coll_st_wb", load_pc_reg_value1, 32'hCAFEF00D);

        init_we   = 1'b1;
        init_addr = 32'h104;
        init_data = 32'h0BADF00D;
        store(32'h104, 32'h12345678);
        init_we = 1'b0;
        load(32'h104);
        check_eq("coll_init_st", read_data, 32'h0BADF00D);
        check_eq("err_clean", {31'h0, mem_err}, 32'h0);

        mem_ctrl_input = MEM_BAD;
        address        = 32'h100;
        w_data         = 32'hFFFFFFFF;
        step();
        mem_ctrl_input = MEM_IDLE;
        check_eq("bad_op_err", {31'h0, mem_err}, 32'h1);
        load(32'h100);
        check_eq("bad_op_nowr", read_data, 32'h11223344);

        do_reset();
        check_eq("err_cleared", {31'h0, mem_err}, 32'h0);
        count_busy(0, cnt);
        load(32'h100);
        check_eq("data_kept", read_data, 32'h11223344);
        load(32'h102);
        check_eq("misal_err", {31'h0, mem_err}, 32'h1);
        check_eq("misal_hold", read_data, 32'h11223344);
        check_eq("misal_noval", {31'h0, mem_valid}, 32'h0);

        do_reset();
        count_busy(0, cnt);
        load(32'h200);
        check_eq("oor_err", {31'h0, mem_err}, 32'h1);
        check_eq("oor_zero", read_data, 32'h0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(0, cnt);
        check_eq("midclr_len", cnt, 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
